// File: rtl/pwm_motor_scheduler_if.sv
// Command port between the flight controller and the PWM motor scheduler.
`timescale 1ns/1ps
interface pwm_motor_scheduler_if #(
  parameter int unsigned W = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4*W-1:0]   cmd_motor;

  modport master (output cmd_valid, output cmd_motor, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_motor, output cmd_ready);
endinterface

// File: rtl/pwm_motor_scheduler.sv
// Shared PWM time base, per-motor width shadowing and arm/failsafe sequencing
// for four pwm_generator_block instances.
`timescale 1ns/1ps
module pwm_motor_scheduler #(
  parameter int unsigned W               = 10,
  parameter int unsigned PERIOD_US       = 20000,
  parameter int unsigned MIN_HIGH_US     = 1000,
  parameter int unsigned MAX_HIGH_US     = 2000,
  parameter int unsigned ARM_PERIODS     = 50,
  parameter int unsigned TIMEOUT_PERIODS = 25
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic                   arm_req,
  pwm_motor_scheduler_if.slave   cmd_if,
  output logic [15:0]            period_counter,
  output logic [W-1:0]           high_counter,
  output logic [4*W-1:0]         motor_val_bus,
  output logic                   period_start,
  output logic                   armed,
  output logic                   failsafe
);

  localparam int unsigned SPAN  = MAX_HIGH_US - MIN_HIGH_US;
  localparam int unsigned ARM_W = $clog2(ARM_PERIODS + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [4*W-1:0] ONES_BUS = {4{W'(1)}};

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMING   = 2'd1,
    S_ARMED    = 2'd2,
    S_FAILSAFE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_period_counter;
  logic [15:0]       w_pc_next;
  logic [W-1:0]      r_high_counter;
  logic              r_period_start;
  logic [4*W-1:0]    r_motor_val;
  logic [4*W-1:0]    r_shadow;
  logic [4*W-1:0]    w_clamped;
  logic [ARM_W-1:0]  r_arm_cnt;
  logic [ARM_W-1:0]  w_arm_cnt_next;
  logic [WD_W-1:0]   r_wd;
  logic              r_cmd_ready;
  logic              r_armed;
  logic              r_failsafe;
  logic              w_boundary;
  logic              w_xfer;
  logic              w_shadow_zero;
  logic              w_use_shadow;
  logic              w_enter_armed;

  // Clamp a commanded width into [1, MAX_HIGH_US-MIN_HIGH_US].
  function automatic logic [W-1:0] clamp_val(input logic [W-1:0] v);
    if (v == '0)             return W'(1);
    else if (v > W'(SPAN))   return W'(SPAN);
    else                     return v;
  endfunction

  assign w_boundary    = (r_period_counter == 16'(PERIOD_US));
  assign w_pc_next     = w_boundary ? 16'd1 : (r_period_counter + 16'd1);
  assign w_xfer        = cmd_if.cmd_valid & r_cmd_ready;
  assign w_shadow_zero = (r_shadow == '0);
  assign w_enter_armed = w_boundary && (w_state_next == S_ARMED) && (r_state != S_ARMED);

  // Clamped view of the shadow, used only when ARMED holds across a boundary.
  always_comb begin
    w_clamped = '0;
    for (int n = 0; n < 4; n++) begin
      w_clamped[n*W +: W] = clamp_val(r_shadow[n*W +: W]);
    end
  end

  // Time base, high-time counter and boundary pulse.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_period_counter <= '0;
      r_high_counter   <= '0;
      r_period_start   <= 1'b0;
    end else begin
      r_period_counter <= w_pc_next;
      r_high_counter   <= (w_pc_next >= 16'(MIN_HIGH_US)) ?
                          W'(w_pc_next - 16'(MIN_HIGH_US)) : '0;
      r_period_start   <= (w_pc_next == 16'(PERIOD_US));
    end
  end

  // Command acceptance into the shadow register.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd_ready <= 1'b0;
      r_shadow    <= '0;
    end else begin
      r_cmd_ready <= 1'b1;
      if (w_xfer) r_shadow <= cmd_if.cmd_motor;
    end
  end

  // Command-stream watchdog, counted in period boundaries.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_wd <= '0;
    end else if (w_xfer || w_enter_armed) begin
      r_wd <= '0;
    end else if (w_boundary && (r_wd != WD_W'(TIMEOUT_PERIODS))) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // FSM state register plus registered status outputs and applied widths.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_DISARMED;
      r_arm_cnt   <= '0;
      r_armed     <= 1'b0;
      r_failsafe  <= 1'b0;
      r_motor_val <= ONES_BUS;
    end else begin
      r_state    <= w_state_next;
      r_arm_cnt  <= w_arm_cnt_next;
      r_armed    <= (w_state_next == S_ARMED);
      r_failsafe <= (w_state_next == S_FAILSAFE);
      if (w_boundary) r_motor_val <= w_use_shadow ? w_clamped : ONES_BUS;
    end
  end

  // Next-state logic; every transition is gated by the period boundary.
  always_comb begin
    w_state_next   = r_state;
    w_arm_cnt_next = r_arm_cnt;
    w_use_shadow   = 1'b0;
    if (w_boundary) begin
      case (r_state)
        S_DISARMED: begin
          if (arm_req && w_shadow_zero) begin
            w_state_next   = S_ARMING;
            w_arm_cnt_next = '0;
          end
        end
        S_ARMING: begin
          if (!arm_req) begin
            w_state_next = S_DISARMED;
          end else if (!w_shadow_zero) begin
            w_arm_cnt_next = '0;
          end else if (r_arm_cnt == ARM_W'(ARM_PERIODS - 1)) begin
            w_state_next = S_ARMED;
          end else begin
            w_arm_cnt_next = r_arm_cnt + ARM_W'(1);
          end
        end
        S_ARMED: begin
          if (!arm_req) begin
            w_state_next = S_DISARMED;
          end else if (r_wd == WD_W'(TIMEOUT_PERIODS)) begin
            w_state_next = S_FAILSAFE;
          end else begin
            w_use_shadow = 1'b1;
          end
        end
        S_FAILSAFE: begin
          if (!arm_req) w_state_next = S_DISARMED;
        end
        default: w_state_next = S_DISARMED;
      endcase
    end
  end

  assign cmd_if.cmd_ready = r_cmd_ready;
  assign period_counter   = r_period_counter;
  assign high_counter     = r_high_counter;
  assign motor_val_bus    = r_motor_val;
  assign period_start     = r_period_start;
  assign armed            = r_armed;
  assign failsafe         = r_failsafe;

endmodule

// File: tb/tb_pwm_motor_scheduler.sv
// Bench for pwm_motor_scheduler: time-base vector table, scoreboarded width
// application, boundary collision, failsafe and mid-period reset.
`timescale 1ns/1ps
module tb_pwm_motor_scheduler;

  localparam int unsigned W      = 10;
  localparam int unsigned PERIOD = 100;
  localparam int unsigned MINH   = 10;
  localparam int unsigned MAXH   = 30;
  localparam int unsigned ARMP   = 2;
  localparam int unsigned TOP    = 3;
  localparam logic [4*W-1:0] ONES = {4{W'(1)}};

  logic            us_clk = 1'b0;
  logic            resetn;
  logic            arm_req;
  logic [15:0]     period_counter;
  logic [W-1:0]    high_counter;
  logic [4*W-1:0]  motor_val_bus;
  logic            period_start;
  logic            armed;
  logic            failsafe;

  pwm_motor_scheduler_if #(.W(W)) cmd_if ();

  pwm_motor_scheduler #(
    .W(W), .PERIOD_US(PERIOD), .MIN_HIGH_US(MINH), .MAX_HIGH_US(MAXH),
    .ARM_PERIODS(ARMP), .TIMEOUT_PERIODS(TOP)
  ) u_dut (
    .us_clk         (us_clk),
    .resetn         (resetn),
    .arm_req        (arm_req),
    .cmd_if         (cmd_if),
    .period_counter (period_counter),
    .high_counter   (high_counter),
    .motor_val_bus  (motor_val_bus),
    .period_start   (period_start),
    .armed          (armed),
    .failsafe       (failsafe)
  );

  always #5 us_clk = ~us_clk;

  typedef struct {
    int           k;
    logic [15:0]  pc;
    logic [W-1:0] hc;
    logic         ps;
    logic         arm;
  } tb_vec_t;

  tb_vec_t          vecs [11];
  int               checks   = 0;
  int               failures = 0;
  int               k        = 0;
  bit               mon_en   = 1'b0;
  logic [4*W-1:0]   mon_prev;
  logic [4*W-1:0]   sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic tick();
    @(negedge us_clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic send(input logic [4*W-1:0] m);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_motor = m;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},     64'(period_counter), 64'd0);
    chk({tag, "_hc"},     64'(high_counter),   64'd0);
    chk({tag, "_bus"},    64'(motor_val_bus),  64'(ONES));
    chk({tag, "_ps"},     64'(period_start),   64'd0);
    chk({tag, "_armed"},  64'(armed),          64'd0);
    chk({tag, "_fs"},     64'(failsafe),       64'd0);
    chk({tag, "_ready"},  64'(cmd_if.cmd_ready), 64'd0);
  endtask

  // Scoreboard: every change of the applied widths must match the next expected entry.
  always @(negedge us_clk) begin
    if (mon_en && (motor_val_bus !== mon_prev)) begin
      if (sb_q.size() == 0) chk("bus_unexpected_change", 64'(motor_val_bus), 64'(mon_prev));
      else                  chk("bus_scoreboard", 64'(motor_val_bus), 64'(sb_q.pop_front()));
      mon_prev = motor_val_bus;
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout k=%0d actual=running required=finished", k);
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{1,   16'd1,   10'd0,  1'b0, 1'b0};
    vecs[1]  = '{10,  16'd10,  10'd0,  1'b0, 1'b0};
    vecs[2]  = '{11,  16'd11,  10'd1,  1'b0, 1'b0};
    vecs[3]  = '{15,  16'd15,  10'd5,  1'b0, 1'b0};
    vecs[4]  = '{100, 16'd100, 10'd90, 1'b1, 1'b0};
    vecs[5]  = '{101, 16'd1,   10'd0,  1'b0, 1'b0};
    vecs[6]  = '{130, 16'd30,  10'd20, 1'b0, 1'b0};
    vecs[7]  = '{200, 16'd100, 10'd90, 1'b1, 1'b0};
    vecs[8]  = '{201, 16'd1,   10'd0,  1'b0, 1'b0};
    vecs[9]  = '{300, 16'd100, 10'd90, 1'b1, 1'b0};
    vecs[10] = '{301, 16'd1,   10'd0,  1'b0, 1'b1};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_motor = '0;
    arm_req = 1'b0;
    resetn  = 1'b0;
    repeat (3) @(negedge us_clk);
    chk_reset_vals("rst");

    arm_req  = 1'b1;
    resetn   = 1'b1;
    k        = 0;
    mon_prev = motor_val_bus;
    mon_en   = 1'b1;

    // Time base and arming, zero throttle held in the shadow.
    for (int i = 0; i < 11; i++) begin
      run_to(vecs[i].k);
      chk("tb_pc",    64'(period_counter), 64'(vecs[i].pc));
      chk("tb_hc",    64'(high_counter),   64'(vecs[i].hc));
      chk("tb_ps",    64'(period_start),   64'(vecs[i].ps));
      chk("tb_armed", 64'(armed),          64'(vecs[i].arm));
      chk("tb_bus",   64'(motor_val_bus),  64'(ONES));
    end
    chk("ready_up", 64'(cmd_if.cmd_ready), 64'd1);

    // Mid-period command: held until the next boundary, then clamped.
    run_to(350);
    send(pack4(5, 0, 25, 40));
    sb_q.push_back(pack4(5, 1, 20, 20));
    run_to(400);
    chk("apply_before_boundary", 64'(motor_val_bus), 64'(ONES));
    run_to(401);
    chk("apply_at_boundary", 64'(motor_val_bus), 64'(pack4(5, 1, 20, 20)));
    chk("pulse_m0", 64'(MINH + motor_val_bus[0*W +: W]), 64'd15);
    chk("pulse_m1", 64'(MINH + motor_val_bus[1*W +: W]), 64'd11);
    chk("pulse_m2", 64'(MINH + motor_val_bus[2*W +: W]), 64'd30);
    chk("pulse_m3", 64'(MINH + motor_val_bus[3*W +: W]), 64'd30);

    // Transfer on the boundary cycle lands one period later.
    run_to(500);
    chk("collide_is_boundary", 64'(period_start), 64'd1);
    send(pack4(7, 8, 9, 10));
    sb_q.push_back(pack4(7, 8, 9, 10));
    chk("collide_old_kept", 64'(motor_val_bus), 64'(pack4(5, 1, 20, 20)));
    run_to(600);
    chk("collide_still_old", 64'(motor_val_bus), 64'(pack4(5, 1, 20, 20)));
    run_to(601);
    chk("collide_applied", 64'(motor_val_bus), 64'(pack4(7, 8, 9, 10)));

    // Command stream stops: watchdog saturates then failsafe forces minimum.
    run_to(900);
    chk("pre_fs_armed", 64'(armed),    64'd1);
    chk("pre_fs_fs",    64'(failsafe), 64'd0);
    sb_q.push_back(ONES);
    run_to(901);
    chk("fs_fs",    64'(failsafe),      64'd1);
    chk("fs_armed", 64'(armed),         64'd0);
    chk("fs_bus",   64'(motor_val_bus), 64'(ONES));

    run_to(950);
    send(pack4(3, 3, 3, 3));
    run_to(1001);
    chk("fs_ignore_bus",   64'(motor_val_bus),    64'(ONES));
    chk("fs_ignore_fs",    64'(failsafe),         64'd1);
    chk("fs_ready",        64'(cmd_if.cmd_ready), 64'd1);

    run_to(1050);
    arm_req = 1'b0;
    run_to(1100);
    chk("fs_hold", 64'(failsafe), 64'd1);
    run_to(1101);
    chk("disarm_fs",    64'(failsafe),      64'd0);
    chk("disarm_armed", 64'(armed),         64'd0);
    chk("disarm_bus",   64'(motor_val_bus), 64'(ONES));

    // Re-arm with zero throttle; the watchdog must restart on entry to ARMED.
    run_to(1110);
    arm_req = 1'b1;
    send(pack4(0, 0, 0, 0));
    run_to(1400);
    chk("rearm_pre", 64'(armed), 64'd0);
    run_to(1401);
    chk("rearm_armed", 64'(armed),    64'd1);
    chk("rearm_fs",    64'(failsafe), 64'd0);
    run_to(1420);
    send(pack4(12, 12, 12, 12));
    sb_q.push_back(pack4(12, 12, 12, 12));
    run_to(1500);
    chk("rearm_before", 64'(motor_val_bus), 64'(ONES));
    run_to(1501);
    chk("rearm_apply",  64'(motor_val_bus), 64'(pack4(12, 12, 12, 12)));
    chk("rearm_still",  64'(armed),         64'd1);

    // Reset mid-pulse while armed.
    run_to(1550);
    chk("mid_pc", 64'(period_counter), 64'd50);
    sb_q.push_back(ONES);
    resetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    resetn = 1'b1;
    k = 0;
    send(pack4(9, 9, 9, 9));
    run_to(250);
    chk("post_rst_armed", 64'(armed),         64'd0);
    chk("post_rst_fs",    64'(failsafe),      64'd0);
    chk("post_rst_bus",   64'(motor_val_bus), 64'(ONES));
    chk("post_rst_pc",    64'(period_counter), 64'd50);
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
